// File: rtl/bcd_conv_seq_if.sv
// -----------------------------------------------------------------------------
// bcd_conv_seq_if
// Handshake bundle between the upstream register bank and the sequential
// binary-to-BCD converter.
//
//   in_valid    upstream -> converter   input word valid
//   in_ready    converter -> upstream   converter can accept a word
//   in_data     upstream -> converter   unsigned binary value
//   out_valid   converter -> consumer   result valid
//   out_ready   consumer -> converter   consumer accepts result
//   out_bcd     converter -> consumer   packed BCD, digit 0 (units) in [3:0]
//   out_ndigits converter -> consumer   count of significant digits (1 for 0)
//   out_ovf     converter -> consumer   value did not fit in DIGITS digits
//
// Modports: master = upstream/consumer side, slave = converter side.
// -----------------------------------------------------------------------------
interface bcd_conv_seq_if #(
   parameter int BIN_WIDTH = 32,
   parameter int DIGITS    = 10
);
   localparam int NDW = $clog2(DIGITS + 1);

   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_WIDTH-1:0]  in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   out_bcd;
   logic [NDW-1:0]        out_ndigits;
   logic                  out_ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_bcd, out_ndigits, out_ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_bcd, out_ndigits, out_ovf
   );
endinterface

// File: rtl/bcd_conv_seq.sv
// -----------------------------------------------------------------------------
// bcd_conv_seq
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One conversion is in flight at a time; BIN_WIDTH shift steps are taken per
// word, and the result is held on the output handshake until consumed.
//
// Ports:
//   ACLK    clock, all state on the rising edge
//   ARESET  asynchronous, active-high reset
//   bus     bcd_conv_seq_if.slave (input and output valid/ready handshakes)
// -----------------------------------------------------------------------------
module bcd_conv_seq #(
   parameter int BIN_WIDTH = 32,
   parameter int DIGITS    = 10
) (
   input  logic           ACLK,
   input  logic           ARESET,
   bcd_conv_seq_if.slave  bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int NDW   = $clog2(DIGITS + 1);
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Applies the add-3 correction to every digit that is 5 or more, so that
   // the following left shift carries correctly into the next decade.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) begin
            res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         end else begin
            res[4*d +: 4] = bcd[4*d +: 4];
         end
      end
      return res;
   endfunction

   // Index of the highest nonzero digit plus one; an all-zero value counts
   // as one significant digit.
   function automatic logic [NDW-1:0] count_digits(input logic [BCD_W-1:0] bcd);
      logic [NDW-1:0] n;
      n = NDW'(1);
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] != 4'd0) begin
            n = NDW'(d + 1);
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // Registered state
   state_t                r_state;
   logic [BCD_W-1:0]      r_bcd;
   logic [BIN_WIDTH-1:0]  r_bin;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_ovf;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [BCD_W-1:0]      r_out_bcd;
   logic [NDW-1:0]        r_out_ndigits;
   logic                  r_out_ovf;

   // Next-state values
   state_t                w_state_nxt;
   logic [BCD_W-1:0]      w_bcd_nxt;
   logic [BIN_WIDTH-1:0]  w_bin_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_ovf_nxt;
   logic                  w_in_ready_nxt;
   logic                  w_out_valid_nxt;
   logic [BCD_W-1:0]      w_out_bcd_nxt;
   logic [NDW-1:0]        w_out_ndigits_nxt;
   logic                  w_out_ovf_nxt;

   // One double-dabble step
   logic [BCD_W-1:0]      w_adj;
   logic [BCD_W-1:0]      w_step_bcd;
   logic [BIN_WIDTH-1:0]  w_step_bin;
   logic                  w_step_carry;

   // Datapath for a single conversion step: correct, then shift {bcd, bin}.
   always_comb begin
      w_adj = add3_digits(r_bcd);
      // The bit leaving the top digit is the overflow carry out of DIGITS.
      {w_step_carry, w_step_bcd, w_step_bin} = {w_adj, r_bin, 1'b0};
   end

   // Next-state and output decode of the IDLE/SHIFT/DONE controller.
   always_comb begin
      w_state_nxt       = r_state;
      w_bcd_nxt         = r_bcd;
      w_bin_nxt         = r_bin;
      w_cnt_nxt         = r_cnt;
      w_ovf_nxt         = r_ovf;
      w_in_ready_nxt    = r_in_ready;
      w_out_valid_nxt   = r_out_valid;
      w_out_bcd_nxt     = r_out_bcd;
      w_out_ndigits_nxt = r_out_ndigits;
      w_out_ovf_nxt     = r_out_ovf;

      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid && r_in_ready) begin
               // in_data is only ever sampled here, on an accepted word.
               w_state_nxt    = ST_SHIFT;
               w_bin_nxt      = bus.in_data;
               w_bcd_nxt      = {BCD_W{1'b0}};
               w_ovf_nxt      = 1'b0;
               w_cnt_nxt      = CNT_W'(BIN_WIDTH);
               w_in_ready_nxt = 1'b0;
            end else begin
               w_in_ready_nxt = 1'b1;
            end
         end

         ST_SHIFT: begin
            w_bcd_nxt = w_step_bcd;
            w_bin_nxt = w_step_bin;
            w_ovf_nxt = r_ovf | w_step_carry;
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               // Last step: publish the freshly shifted digits directly so the
               // result appears on the BIN_WIDTH-th edge after acceptance.
               w_state_nxt       = ST_DONE;
               w_out_valid_nxt   = 1'b1;
               w_out_bcd_nxt     = w_step_bcd;
               w_out_ndigits_nxt = count_digits(w_step_bcd);
               w_out_ovf_nxt     = r_ovf | w_step_carry;
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end

         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt     = ST_IDLE;
               w_out_valid_nxt = 1'b0;
               w_in_ready_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end

         default: begin
            // Unreachable encoding: recover to a clean idle without a result.
            w_state_nxt     = ST_IDLE;
            w_in_ready_nxt  = 1'b1;
            w_out_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state       <= ST_IDLE;
         r_bcd         <= {BCD_W{1'b0}};
         r_bin         <= {BIN_WIDTH{1'b0}};
         r_cnt         <= {CNT_W{1'b0}};
         r_ovf         <= 1'b0;
         r_in_ready    <= 1'b1;
         r_out_valid   <= 1'b0;
         r_out_bcd     <= {BCD_W{1'b0}};
         r_out_ndigits <= {NDW{1'b0}};
         r_out_ovf     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_bcd         <= w_bcd_nxt;
         r_bin         <= w_bin_nxt;
         r_cnt         <= w_cnt_nxt;
         r_ovf         <= w_ovf_nxt;
         r_in_ready    <= w_in_ready_nxt;
         r_out_valid   <= w_out_valid_nxt;
         r_out_bcd     <= w_out_bcd_nxt;
         r_out_ndigits <= w_out_ndigits_nxt;
         r_out_ovf     <= w_out_ovf_nxt;
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_bcd     = r_out_bcd;
   assign bus.out_ndigits = r_out_ndigits;
   assign bus.out_ovf     = r_out_ovf;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_conv_seq
// Self-checking bench for bcd_conv_seq: a 10-digit instance for the main
// function and a 2-digit instance for overflow. Expected results come from a
// divide/modulo reference model and are queued when a word is accepted.
// -----------------------------------------------------------------------------
module tb_bcd_conv_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   bcd_conv_seq_if #(.BIN_WIDTH(32), .DIGITS(10)) bus  ();
   bcd_conv_seq_if #(.BIN_WIDTH(32), .DIGITS(2))  bus2 ();

   bcd_conv_seq #(.BIN_WIDTH(32), .DIGITS(10)) u_dut (
      .ACLK   (clk),
      .ARESET (rst),
      .bus    (bus)
   );

   bcd_conv_seq #(.BIN_WIDTH(32), .DIGITS(2)) u_dut2 (
      .ACLK   (clk),
      .ARESET (rst),
      .bus    (bus2)
   );

   typedef struct packed {
      logic [39:0] bcd;
      logic [3:0]  nd;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   exp_t sb2[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic exp_t ref_conv(input logic [31:0] v, input int digits);
      exp_t           e;
      longint unsigned x;
      longint unsigned r;
      e    = '0;
      e.nd = 4'd1;
      x    = 64'(v);
      for (int d = 0; d < digits; d++) begin
         r = x % 64'd10;
         e.bcd[4*d +: 4] = 4'(r);
         if (r != 64'd0) e.nd = 4'(d + 1);
         x = x / 64'd10;
      end
      e.ovf = (x != 64'd0);
      return e;
   endfunction

   // Offer a word to the 10-digit DUT; queue its expected result on acceptance.
   task automatic put_word(input logic [31:0] v, output bit ok);
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      for (int i = 0; i < 200; i++) begin
         if (bus.in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      if (ok) sb.push_back(ref_conv(v, 10));
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 32'h0;
   endtask

   // Collect one result from the 10-digit DUT; cycles counts negedges waited.
   task automatic get_result(output exp_t got, output int cycles, output bit ok);
      ok     = 1'b0;
      cycles = 0;
      got    = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (bus.out_valid === 1'b1) begin
            got.bcd = bus.out_bcd;
            got.nd  = bus.out_ndigits;
            got.ovf = bus.out_ovf;
            ok      = 1'b1;
            break;
         end
         @(negedge clk);
         cycles++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
      end
      n_tests++;
      if (bus.out_bcd !== 40'h0 || bus.out_ndigits !== 4'd0 || bus.out_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_data: bcd=%h nd=%0d ovf=%b, required 0 0 0", bus.out_bcd, bus.out_ndigits, bus.out_ovf);
      end
      n_tests++;
      if (bus2.in_ready !== 1'b1 || bus2.out_valid !== 1'b0 || bus2.out_bcd !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_d2: in_ready=%b out_valid=%b bcd=%h, required 1 0 00", bus2.in_ready, bus2.out_valid, bus2.out_bcd);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_latency();
      bit   ok;
      bit   busy_bad;
      int   valid_at;
      exp_t e;
      put_word(32'd0, ok);
      busy_bad = (bus.in_ready !== 1'b0);
      valid_at = -1;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
         if (bus.out_valid === 1'b1 && valid_at < 0) valid_at = k;
      end
      n_tests++;
      if (!ok || valid_at != 32) begin
         n_fail++;
         $display("FAIL latency_zero: out_valid first seen %0d cycles after accept, required 32", valid_at);
      end
      n_tests++;
      if (busy_bad) begin
         n_fail++;
         $display("FAIL in_ready_busy: in_ready was 1 during conversion/DONE, required 0");
      end
      e = sb.pop_front();
      n_tests++;
      if (bus.out_bcd !== e.bcd || bus.out_ndigits !== e.nd || bus.out_ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL result_zero: bcd=%h nd=%0d ovf=%b, required %h %0d %b",
                  bus.out_bcd, bus.out_ndigits, bus.out_ovf, e.bcd, e.nd, e.ovf);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL consume_zero: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_values();
      logic [31:0] vals [2];
      exp_t        got;
      exp_t        e;
      int          cyc;
      bit          ok_in;
      bit          ok_out;
      vals[0] = 32'd1234;
      vals[1] = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         put_word(vals[i], ok_in);
         get_result(got, cyc, ok_out);
         n_tests++;
         if (!ok_in || !ok_out) begin
            n_fail++;
            $display("FAIL value_%0d: handshake timeout in=%b out=%b, required 1 1", i, ok_in, ok_out);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL value_%0d: bcd=%h nd=%0d ovf=%b, required %h %0d %b",
                        i, got.bcd, got.nd, got.ovf, e.bcd, e.nd, e.ovf);
            end
         end
      end
      n_tests++;
      if (got.bcd !== 40'h4294967295 || got.nd !== 4'd10) begin
         n_fail++;
         $display("FAIL value_max: bcd=%h nd=%0d, required 4294967295 10", got.bcd, got.nd);
      end
   endtask

   task automatic test_backpressure();
      bit   ok;
      bit   seen;
      bit   hold_bad;
      exp_t e;
      exp_t got;
      int   cyc;
      put_word(32'd99, ok);
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (bus.out_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd7;
      e = sb[0];
      hold_bad = !seen;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_bcd !== e.bcd) hold_bad = 1'b1;
      end
      n_tests++;
      if (hold_bad) begin
         n_fail++;
         $display("FAIL backpressure_hold: out_valid=%b in_ready=%b bcd=%h, required 1 0 %h",
                  bus.out_valid, bus.in_ready, bus.out_bcd, e.bcd);
      end
      void'(sb.pop_front());
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      put_word(32'd7, ok);
      get_result(got, cyc, seen);
      n_tests++;
      if (!ok || !seen) begin
         n_fail++;
         $display("FAIL backpressure_next: handshake timeout in=%b out=%b, required 1 1", ok, seen);
      end else begin
         e = sb.pop_front();
         if (got !== e) begin
            n_fail++;
            $display("FAIL backpressure_next: bcd=%h nd=%0d, required %h %0d", got.bcd, got.nd, e.bcd, e.nd);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit   ok;
      bit   ok_out;
      exp_t got;
      exp_t e;
      int   cyc;
      put_word(32'd5000, ok);
      repeat (9) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.out_bcd !== 40'h0 || bus.in_ready !== 1'b1 ||
          bus.out_ndigits !== 4'd0 || bus.out_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: out_valid=%b bcd=%h in_ready=%b nd=%0d ovf=%b, required 0 0 1 0 0",
                  bus.out_valid, bus.out_bcd, bus.in_ready, bus.out_ndigits, bus.out_ovf);
      end
      if (ok) void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      put_word(32'd42, ok);
      get_result(got, cyc, ok_out);
      n_tests++;
      if (!ok || !ok_out || cyc != 32) begin
         n_fail++;
         $display("FAIL reset_mid_latency: latency=%0d ok=%b%b, required 32 11", cyc, ok, ok_out);
      end
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL reset_mid_value: no expectation queued, required 1");
      end else begin
         e = sb.pop_front();
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset_mid_value: bcd=%h nd=%0d, required %h %0d", got.bcd, got.nd, e.bcd, e.nd);
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] vals [2];
      exp_t        e;
      bit          seen;
      vals[0] = 32'd100;
      vals[1] = 32'd99;
      for (int i = 0; i < 2; i++) begin
         bus2.in_valid = 1'b1;
         bus2.in_data  = vals[i];
         n_tests++;
         if (bus2.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_ready_%0d: in_ready=%b, required 1", i, bus2.in_ready);
         end
         @(posedge clk);
         sb2.push_back(ref_conv(vals[i], 2));
         @(negedge clk);
         bus2.in_valid = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 100; c++) begin
            if (bus2.out_valid === 1'b1) begin
               seen = 1'b1;
               break;
            end
            @(negedge clk);
         end
         e = sb2.pop_front();
         n_tests++;
         if (!seen) begin
            n_fail++;
            $display("FAIL ovf_%0d: out_valid timeout, required 1", i);
         end else if (bus2.out_bcd !== e.bcd[7:0] || bus2.out_ndigits !== e.nd[1:0] || bus2.out_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL ovf_%0d: bcd=%h nd=%0d ovf=%b, required %h %0d %b",
                     i, bus2.out_bcd, bus2.out_ndigits, bus2.out_ovf, e.bcd[7:0], e.nd[1:0], e.ovf);
         end
         bus2.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus2.out_ready = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      int n_rx;
      n_rx = 0;
      fork
         begin : producer
            bit          ok;
            logic [31:0] v;
            for (int i = 0; i < 1000; i++) begin
               case ($urandom_range(0, 3))
                  0:       v = $urandom;
                  1:       v = $urandom_range(0, 9999);
                  2:       v = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'd0;
                  default: v = $urandom_range(999_999_990, 1_000_000_010);
               endcase
               put_word(v, ok);
               if (!ok) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL stream_accept: word %0d not accepted in 200 cycles", i);
                  break;
               end
               repeat ($urandom_range(0, 1)) @(negedge clk);
            end
         end
         begin : consumer
            bit   ok;
            exp_t got;
            exp_t e;
            int   cyc;
            for (int i = 0; i < 1000; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               get_result(got, cyc, ok);
               n_tests++;
               if (!ok) begin
                  n_fail++;
                  $display("FAIL stream_result: result %0d timeout", i);
                  break;
               end else if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL stream_result: result %0d with empty scoreboard, bcd=%h", i, got.bcd);
               end else begin
                  e = sb.pop_front();
                  n_rx++;
                  if (got !== e) begin
                     n_fail++;
                     $display("FAIL stream_result: #%0d bcd=%h nd=%0d ovf=%b, required %h %0d %b",
                              i, got.bcd, got.nd, got.ovf, e.bcd, e.nd, e.ovf);
                  end
               end
            end
         end
      join
      n_tests++;
      if (n_rx != 1000 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL stream_count: received %0d with %0d left queued, required 1000 and 0", n_rx, sb.size());
      end
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = 32'h0;
      bus.out_ready  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = 32'h0;
      bus2.out_ready = 1'b0;
      test_reset();
      test_zero_latency();
      test_values();
      test_backpressure();
      test_reset_mid();
      test_overflow();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_conv_seq.md
Name: bcd_conv_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, "double dabble").
- Sits directly downstream of the bcd_Axi AXI4-Lite slave register bank: a value written into a slave register is handed over on a valid/ready input; the packed BCD result is handed back on a valid/ready output for the register bank to expose on read.
- One conversion in flight at a time; result held until consumed.

Parameters:
- BIN_WIDTH, 32, width of binary input (matches slave register width).
- DIGITS, 10, number of BCD output digits; 10 covers the full 32-bit range.

Ports:
- ACLK  in  1  clock, all state on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept a word.
- in_data  in  BIN_WIDTH  unsigned binary value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_bcd  out  4*DIGITS  packed BCD; digit 0 (units) in [3:0].
- out_ndigits  out  $clog2(DIGITS+1)  count of significant digits; 1 for value 0.
- out_ovf  out  1  value did not fit in DIGITS digits.

Interface decision: one clock; reset is asynchronous and active-high (ACLK, ARESET).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0.
  - out_bcd=0, out_ndigits=0, out_ovf=0.
  - Shift register and bit counter cleared.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: capture in_data into binary shift register, clear BCD accumulator and ovf, load counter=BIN_WIDTH, go SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, for every digit: if digit>=5, add 3.
  - Then shift {bcd, bin} left by 1.
  - The bit shifted out of the top digit ORs into an internal ovf flag.
  - Decrement counter; when counter reaches 1 at an edge, register the results and go DONE.
- Latency: out_valid rises on the BIN_WIDTH-th rising edge after the accepting edge (32 cycles at default).
- DONE:
  - out_valid=1; out_bcd, out_ndigits and out_ovf stable.
  - On out_valid&&out_ready: go IDLE, out_valid=0 next cycle.
  - out_bcd, out_ndigits and out_ovf retain their values until the next result is registered.
- No same-cycle turnaround: in_ready=0 in DONE, so the minimum accept-to-accept interval is BIN_WIDTH+2 cycles.
- in_valid while in_ready=0 is ignored; upstream holds in_valid and in_data per valid/ready rules.
- out_ndigits: index of the highest nonzero digit +1; value 0 gives 1. Computed on final digits, registered with out_bcd.
- Overflow: digits hold value mod 10^DIGITS; out_ovf=1 iff any 1 was shifted out of the top digit.
- Every digit of out_bcd is always 0..9.
- ARESET mid-SHIFT or mid-DONE:
  - Conversion aborted immediately; all outputs return to reset values.
  - No partial result is ever presented.
- X-safety: in_data is sampled only on accept; out_bcd never depends on in_data outside SHIFT.

Test Plan:
- Accept 0 at edge T → out_valid at T+32, out_bcd=0x0000000000, out_ndigits=1, out_ovf=0; in_ready=0 for T+1..T+33.
- Accept 1234 → out_bcd=0x0000001234, out_ndigits=4, out_ovf=0; then 0xFFFFFFFF → out_bcd=0x4294967295, out_ndigits=10, out_ovf=0.
- Backpressure: result 99 ready, out_ready held low 5 cycles, second in_valid with 7 asserted throughout → out_bcd stays 0x0000000099, in_ready stays 0; after out_ready pulse, 7 accepted and converts to 0x0000000007.
- Reset mid-op: accept 5000, assert ARESET asynchronously 10 cycles later → out_valid=0, out_bcd=0, in_ready=1 immediately; after release, 42 converts to 0x0000000042 with correct 32-cycle latency.
- Overflow with DIGITS=2: 100 → out_bcd=0x00, out_ovf=1, out_ndigits=1; 99 → 0x99, out_ovf=0, out_ndigits=2.
- Random back-to-back stream of 1000 values with random out_ready stalls → every result matches the reference model; no accepted input lost or duplicated.
